// File: rtl/a_er_batch_scheduler.sv
// Alice-side ER batch scheduler: picks a full sifted-key half, runs all-frame ER on it,
// accumulates saturating batch totals, hands them to PA and releases the half.
module a_er_batch_scheduler #(
    parameter int LEAK_W  = 16,
    parameter int ERR_W   = 16,
    parameter int TOTAL_W = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         buf_ready,
    output logic [1:0]         buf_release,
    output logic               er_start,
    output logic               er_addr_index,
    input  logic               er_finish,
    input  logic               frame_param_valid,
    input  logic [LEAK_W-1:0]  frame_leaked_info,
    input  logic [ERR_W-1:0]   frame_error_count,
    input  logic               frame_ev_fail,
    output logic               pa_req,
    input  logic               pa_ack,
    output logic [TOTAL_W-1:0] batch_leaked_total,
    output logic [TOTAL_W-1:0] batch_error_total,
    output logic [CNT_W-1:0]   batch_frame_count,
    output logic [CNT_W-1:0]   batch_fail_count,
    output logic               batch_ok,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, RELEASE} state_t;

    // Sum width covers the widest operand plus a carry so saturation can be detected.
    localparam int MAX_IN = (LEAK_W > ERR_W) ? LEAK_W : ERR_W;
    localparam int SUM_W  = ((TOTAL_W > MAX_IN) ? TOTAL_W : MAX_IN) + 1;

    state_t             state_q, state_d;
    logic               idx_q, idx_d;
    logic               last_q, last_d;
    logic [1:0]         mask_q, mask_d;
    logic [TOTAL_W-1:0] leak_q, leak_d;
    logic [TOTAL_W-1:0] err_q, err_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   fail_q, fail_d;

    logic [1:0]         rdy_eff;
    logic [SUM_W-1:0]   tot_max, leak_sum, err_sum;
    logic [TOTAL_W-1:0] leak_sat, err_sat;

    assign rdy_eff  = buf_ready & ~mask_q;
    assign tot_max  = SUM_W'({TOTAL_W{1'b1}});
    assign leak_sum = SUM_W'(leak_q) + SUM_W'(frame_leaked_info);
    assign err_sum  = SUM_W'(err_q) + SUM_W'(frame_error_count);
    assign leak_sat = (leak_sum > tot_max) ? '1 : leak_sum[TOTAL_W-1:0];
    assign err_sat  = (err_sum > tot_max) ? '1 : err_sum[TOTAL_W-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        mask_d  = '0;
        leak_d  = leak_q;
        err_d   = err_q;
        frame_d = frame_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (enable && (rdy_eff != 2'b00)) begin
                    idx_d   = (rdy_eff == 2'b11) ? ~last_q : rdy_eff[1];
                    leak_d  = '0;
                    err_d   = '0;
                    frame_d = '0;
                    fail_d  = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (frame_param_valid) begin
                    leak_d = leak_sat;
                    err_d  = err_sat;
                    if (frame_q != '1) frame_d = frame_q + CNT_W'(1);
                    if (frame_ev_fail && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);
                end
                if (er_finish) state_d = REPORT;
            end
            REPORT: if (pa_ack) state_d = RELEASE;
            RELEASE: begin
                last_d  = idx_q;
                // Hide the just-released half for one IDLE cycle so sifting can drop its level.
                mask_d  = idx_q ? 2'b10 : 2'b01;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 1'b0;
            last_q  <= 1'b1;
            mask_q  <= '0;
            leak_q  <= '0;
            err_q   <= '0;
            frame_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            leak_q  <= leak_d;
            err_q   <= err_d;
            frame_q <= frame_d;
            fail_q  <= fail_d;
        end
    end

    assign er_start           = (state_q == LAUNCH);
    assign pa_req             = (state_q == REPORT);
    assign busy               = (state_q != IDLE);
    assign buf_release        = (state_q == RELEASE) ? {idx_q, ~idx_q} : 2'b00;
    assign er_addr_index      = idx_q;
    assign batch_leaked_total = leak_q;
    assign batch_error_total  = err_q;
    assign batch_frame_count  = frame_q;
    assign batch_fail_count   = fail_q;
    assign batch_ok           = (fail_q == '0) && (frame_q != '0);

endmodule

// File: tb/tb_a_er_batch_scheduler.sv
// Directed bench for a_er_batch_scheduler: a default instance plus a TOTAL_W=10 instance
// sharing the same stimulus for the saturation case.
module tb_a_er_batch_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  buf_ready;
    logic        er_finish;
    logic        frame_param_valid;
    logic [15:0] frame_leaked_info;
    logic [15:0] frame_error_count;
    logic        frame_ev_fail;
    logic        pa_ack;

    logic [1:0]  buf_release;
    logic        er_start, er_addr_index, pa_req, batch_ok, busy;
    logic [31:0] batch_leaked_total, batch_error_total;
    logic [7:0]  batch_frame_count, batch_fail_count;

    logic [1:0]  s_buf_release;
    logic        s_er_start, s_er_addr_index, s_pa_req, s_batch_ok, s_busy;
    logic [9:0]  s_leak, s_err;
    logic [7:0]  s_frames, s_fails;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    a_er_batch_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .buf_ready(buf_ready),
        .buf_release(buf_release), .er_start(er_start), .er_addr_index(er_addr_index),
        .er_finish(er_finish), .frame_param_valid(frame_param_valid),
        .frame_leaked_info(frame_leaked_info), .frame_error_count(frame_error_count),
        .frame_ev_fail(frame_ev_fail), .pa_req(pa_req), .pa_ack(pa_ack),
        .batch_leaked_total(batch_leaked_total), .batch_error_total(batch_error_total),
        .batch_frame_count(batch_frame_count), .batch_fail_count(batch_fail_count),
        .batch_ok(batch_ok), .busy(busy)
    );

    a_er_batch_scheduler #(.TOTAL_W(10)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .buf_ready(buf_ready),
        .buf_release(s_buf_release), .er_start(s_er_start), .er_addr_index(s_er_addr_index),
        .er_finish(er_finish), .frame_param_valid(frame_param_valid),
        .frame_leaked_info(frame_leaked_info), .frame_error_count(frame_error_count),
        .frame_ev_fail(frame_ev_fail), .pa_req(s_pa_req), .pa_ack(pa_ack),
        .batch_leaked_total(s_leak), .batch_error_total(s_err),
        .batch_frame_count(s_frames), .batch_fail_count(s_fails),
        .batch_ok(s_batch_ok), .busy(s_busy)
    );

    typedef struct {
        bit              rst;
        logic [1:0]      rdy;
        int              n;
        logic [3:0][15:0] leak;
        logic [3:0][15:0] err;
        logic [3:0]      fail;
        bit              fin_last;
        logic            idx;
        logic [31:0]     e_leak;
        logic [31:0]     e_err;
        logic [7:0]      e_fr;
        logic [7:0]      e_fl;
        logic            e_ok;
        logic [1:0]      rel;
        logic [9:0]      s_leak;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_frame();
        frame_param_valid = 1'b0;
        frame_leaked_info = '0;
        frame_error_count = '0;
        frame_ev_fail     = 1'b0;
        er_finish         = 1'b0;
    endtask

    task automatic run_batch(input vec_t v);
        bit seen;
        seen = 1'b0;
        if (v.rst) begin
            rst_n = 1'b0;
            buf_ready = v.rdy;
            step();
            step();
            rst_n = 1'b1;
        end
        buf_ready = v.rdy;
        enable = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (er_start) seen = 1'b1;
        end
        check("launch_seen", seen, 1);
        check("launch_index", er_addr_index, v.idx);
        // Frame and finish during LAUNCH must be ignored.
        frame_param_valid = 1'b1; frame_leaked_info = 16'd7;
        frame_error_count = 16'd7; frame_ev_fail = 1'b1; er_finish = 1'b1;
        step();
        clear_frame();
        check("start_one_cycle", er_start, 0);
        for (int i = 0; i < v.n; i++) begin
            frame_param_valid = 1'b1;
            frame_leaked_info = v.leak[i];
            frame_error_count = v.err[i];
            frame_ev_fail     = v.fail[i];
            if (i == v.n - 1 && v.fin_last) er_finish = 1'b1;
            step();
            clear_frame();
        end
        if (!v.fin_last) begin
            er_finish = 1'b1;
            step();
            er_finish = 1'b0;
        end
        check("pa_req_high", pa_req, 1);
        check("leak_total", batch_leaked_total, v.e_leak);
        check("err_total", batch_error_total, v.e_err);
        check("frame_count", batch_frame_count, v.e_fr);
        check("fail_count", batch_fail_count, v.e_fl);
        check("batch_ok", batch_ok, v.e_ok);
        check("sat_leak_total", s_leak, v.s_leak);
        step();
        check("pa_req_hold", pa_req, 1);
        check("leak_hold", batch_leaked_total, v.e_leak);
        pa_ack = 1'b1;
        step();
        pa_ack = 1'b0;
        check("pa_req_low_after_ack", pa_req, 0);
        check("buf_release", buf_release, v.rel);
        step();
        check("idle_after_release", busy, 0);
        check("release_one_cycle", buf_release, 0);
    endtask

    initial begin
        tbl[0] = '{rst:0, rdy:2'b01, n:3, leak:{16'd0, 16'd300, 16'd200, 16'd100},
                   err:{16'd0, 16'd3, 16'd2, 16'd1}, fail:4'b0000, fin_last:0, idx:1'b0,
                   e_leak:32'd600, e_err:32'd6, e_fr:8'd3, e_fl:8'd0, e_ok:1'b1,
                   rel:2'b01, s_leak:10'd600};
        tbl[1] = '{rst:1, rdy:2'b11, n:1, leak:{16'd0, 16'd0, 16'd0, 16'd5},
                   err:{16'd0, 16'd0, 16'd0, 16'd0}, fail:4'b0000, fin_last:0, idx:1'b0,
                   e_leak:32'd5, e_err:32'd0, e_fr:8'd1, e_fl:8'd0, e_ok:1'b1,
                   rel:2'b01, s_leak:10'd5};
        tbl[2] = '{rst:0, rdy:2'b11, n:2, leak:{16'd0, 16'd0, 16'd20, 16'd10},
                   err:{16'd0, 16'd0, 16'd1, 16'd1}, fail:4'b0000, fin_last:0, idx:1'b1,
                   e_leak:32'd30, e_err:32'd2, e_fr:8'd2, e_fl:8'd0, e_ok:1'b1,
                   rel:2'b10, s_leak:10'd30};
        tbl[3] = '{rst:0, rdy:2'b11, n:1, leak:{16'd0, 16'd0, 16'd0, 16'd7},
                   err:{16'd0, 16'd0, 16'd0, 16'd4}, fail:4'b0000, fin_last:1, idx:1'b0,
                   e_leak:32'd7, e_err:32'd4, e_fr:8'd1, e_fl:8'd0, e_ok:1'b1,
                   rel:2'b01, s_leak:10'd7};
        tbl[4] = '{rst:0, rdy:2'b10, n:4, leak:{16'd4, 16'd3, 16'd2, 16'd1},
                   err:{16'd0, 16'd0, 16'd0, 16'd0}, fail:4'b0010, fin_last:0, idx:1'b1,
                   e_leak:32'd10, e_err:32'd0, e_fr:8'd4, e_fl:8'd1, e_ok:1'b0,
                   rel:2'b10, s_leak:10'd10};
        tbl[5] = '{rst:0, rdy:2'b01, n:2, leak:{16'd0, 16'd0, 16'd100, 16'd1000},
                   err:{16'd0, 16'd0, 16'd1, 16'hFFFF}, fail:4'b0000, fin_last:1, idx:1'b0,
                   e_leak:32'd1100, e_err:32'd65536, e_fr:8'd2, e_fl:8'd0, e_ok:1'b1,
                   rel:2'b01, s_leak:10'd1023};

        rst_n = 1'b0; enable = 1'b0; buf_ready = 2'b00; pa_ack = 1'b0;
        clear_frame();
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_er_start", er_start, 0);
        check("rst_pa_req", pa_req, 0);
        check("rst_buf_release", buf_release, 0);
        check("rst_index", er_addr_index, 0);
        check("rst_leak", batch_leaked_total, 0);
        check("rst_err", batch_error_total, 0);
        check("rst_frames", batch_frame_count, 0);
        check("rst_fails", batch_fail_count, 0);
        check("rst_batch_ok", batch_ok, 0);

        // enable low blocks launch; raising it launches half 1 one cycle later.
        rst_n = 1'b1;
        buf_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            check("disabled_no_start", er_start, 0);
            check("disabled_not_busy", busy, 0);
        end
        enable = 1'b1;
        step();
        check("enable_start", er_start, 1);
        check("enable_index", er_addr_index, 1);
        step();
        for (int i = 0; i < 2; i++) begin
            frame_param_valid = 1'b1; frame_leaked_info = 16'd50; frame_error_count = 16'd2;
            step();
            clear_frame();
        end
        check("mid_run_frames", batch_frame_count, 2);
        rst_n = 1'b0;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_leak", batch_leaked_total, 0);
        check("mid_rst_frames", batch_frame_count, 0);
        check("mid_rst_no_release", buf_release, 0);
        rst_n = 1'b1;
        buf_ready = 2'b00;

        for (int t = 0; t < 6; t++) run_batch(tbl[t]);

        // Released half 0 still ready: masked for the first IDLE cycle only.
        step();
        check("mask_no_start", er_start, 0);
        check("mask_not_busy", busy, 0);
        step();
        check("mask_then_start", er_start, 1);
        check("mask_then_index", er_addr_index, 0);
        // pa_ack held high: release one cycle after REPORT is entered.
        pa_ack = 1'b1;
        step();
        er_finish = 1'b1;
        step();
        er_finish = 1'b0;
        check("held_ack_report", pa_req, 1);
        check("empty_batch_ok", batch_ok, 0);
        buf_ready = 2'b00;
        step();
        check("held_ack_release", buf_release, 2'b01);
        pa_ack = 1'b0;
        step();
        check("held_ack_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
